wb_writeback_arbiter: RTL and testbench

Write-back stage that consumes the MEM/WB pipeline register outputs and owns the single register-file write port. It selects the pipeline result (ALU or load data) and merges in asynchronous CGRA accelerator results through a small posted-write queue. Pipeline writes have priority. Queued CGRA writes drain in idle write-port cycles, and a starvation guard forces a one-cycle pipeline stall when needed. Sits between the MEM/WB register, the register file, the CGRA result port and the hazard unit.

---
 rtl/wb_writeback_arbiter.sv | 101 ++++++++++
 tb/tb_wb_writeback_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/wb_writeback_arbiter.sv
// Write-back stage: owns the single register-file write port, merging pipeline
// results with CGRA accelerator results held in a small posted-write queue.
module wb_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] DataMemReadData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        cgra_valid_i,
  input  logic [4:0]  cgra_rd_i,
  input  logic [31:0] cgra_data_i,
  output logic        cgra_ready_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        Stall_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0]             rd_ptr, wr_ptr;
  logic [CW-1:0]             count;
  logic [DEPTH-1:0]          vld;
  logic [DEPTH-1:0][4:0]     q_rd;
  logic [DEPTH-1:0][31:0]    q_data;
  logic [SW-1:0]             starve_cnt;

  logic not_empty, head_vld, pipe_wr, drain, enq;

  assign not_empty    = (count != '0);
  assign head_vld     = not_empty & vld[rd_ptr];
  assign Stall_o      = ~rst_i & head_vld & (starve_cnt == SW'(STARVE_LIMIT));
  assign pipe_wr      = ~rst_i & RegWrite_i & (RDaddr_i != 5'd0) & ~Stall_o;
  assign drain        = ~rst_i & not_empty & (~pipe_wr | Stall_o);
  assign cgra_ready_o = ~rst_i & (count < CW'(DEPTH));
  // rd==0 completes the handshake but never occupies a slot
  assign enq          = cgra_valid_i & cgra_ready_o & (cgra_rd_i != 5'd0);
  assign busy_o       = |vld;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = 5'd0;
    rf_wdata_o = 32'd0;
    if (drain) begin
      // a killed head still consumes the slot, silently
      if (head_vld) begin
        rf_we_o    = 1'b1;
        rf_waddr_o = q_rd[rd_ptr];
        rf_wdata_o = q_data[rd_ptr];
      end
    end else if (pipe_wr) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = RDaddr_i;
      rf_wdata_o = MemToReg_i ? DataMemReadData_i : ALUResult_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      vld        <= '0;
      starve_cnt <= '0;
    end else begin
      // WAW: an older queued write to the same rd must not land after this one
      for (int i = 0; i < DEPTH; i++)
        if (pipe_wr && q_rd[i] == RDaddr_i) vld[i] <= 1'b0;
      if (drain) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + AW'(1);
      end
      if (enq) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (enq && !drain)      count <= count + CW'(1);
      else if (!enq && drain) count <= count - CW'(1);
      if (drain || !not_empty)
        starve_cnt <= '0;
      else if (head_vld && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      q_rd[wr_ptr]   <= cgra_rd_i;
      q_data[wr_ptr] <= cgra_data_i;
    end
  end

endmodule

// File: tb/tb_wb_writeback_arbiter.sv
// Directed bench for wb_writeback_arbiter: inputs change 1ns after a rising
// edge, combinational outputs are sampled 1ns later.
module tb_wb_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu, dmem, cdata;
  logic [4:0]  rdaddr, crd;
  logic        regwrite, memtoreg, cvalid;
  logic        cready, we, stall, busy;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rf [32];
  int nvec = 0;
  int nerr = 0;

  wb_writeback_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .ALUResult_i(alu), .DataMemReadData_i(dmem), .RDaddr_i(rdaddr),
    .RegWrite_i(regwrite), .MemToReg_i(memtoreg),
    .cgra_valid_i(cvalid), .cgra_rd_i(crd), .cgra_data_i(cdata),
    .cgra_ready_o(cready), .rf_we_o(we), .rf_waddr_o(waddr),
    .rf_wdata_o(wdata), .Stall_o(stall), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // register file as the DUT would see it
  always @(posedge clk) if (we) rf[waddr] <= wdata;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; regwrite = 1'b1; rdaddr = 5'd5; alu = 32'h1;
    for (int n = 0; n < 2; n++) begin
      cyc(); #1;
      nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL reset_we: got %b want 0", we); end
      nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall: got %b want 0", stall); end
    end
    cyc();
    rst = 1'b0; regwrite = 1'b0; #1;
    nvec++; if (cready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b want 1", cready); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %b want 0", busy); end
    nvec++; if (stall !== 1'b0) begin nerr++; $display("FAIL reset_stall_after: got %b want 0", stall); end
  endtask

  task automatic test_pipe_select();
    cyc();
    regwrite = 1'b1; rdaddr = 5'd5; memtoreg = 1'b1; dmem = 32'hDEADBEEF; alu = 32'h0; #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      nerr++; $display("FAIL pipe_load: got we=%b a=%0d d=%h want 1 5 deadbeef", we, waddr, wdata); end
    cyc();
    memtoreg = 1'b0; alu = 32'h12; #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h12) begin
      nerr++; $display("FAIL pipe_alu: got we=%b a=%0d d=%h want 1 5 12", we, waddr, wdata); end
    cyc();
    rdaddr = 5'd0; #1;
    nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL pipe_rd0: got we=%b want 0", we); end
    cyc();
    regwrite = 1'b0;
  endtask

  task automatic test_drain();
    cyc();
    cvalid = 1'b1; crd = 5'd7; cdata = 32'hA5A5A5A5; #1;
    nvec++; if (cready !== 1'b1 || we !== 1'b0) begin
      nerr++; $display("FAIL drain_push: got ready=%b we=%b want 1 0", cready, we); end
    cyc();
    cvalid = 1'b0; #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd7 || wdata !== 32'hA5A5A5A5) begin
      nerr++; $display("FAIL drain_write: got we=%b a=%0d d=%h want 1 7 a5a5a5a5", we, waddr, wdata); end
    cyc(); #1;
    nvec++; if (busy !== 1'b0 || we !== 1'b0) begin
      nerr++; $display("FAIL drain_empty: got busy=%b we=%b want 0 0", busy, we); end
  endtask

  task automatic test_full_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 1; i <= 4; i++) begin
        cyc();
        cvalid = 1'b1; crd = 5'(i); cdata = 32'(r * 16 + i);
        regwrite = 1'b1; rdaddr = 5'd9; memtoreg = 1'b0; alu = 32'h900 + 32'(r); #1;
        nvec++; if (cready !== 1'b1 || we !== 1'b1 || waddr !== 5'd9) begin
          nerr++; $display("FAIL full_push r%0d i%0d: got ready=%b we=%b a=%0d want 1 1 9", r, i, cready, we, waddr); end
      end
      cyc();
      cvalid = 1'b0; #1;
      nvec++; if (cready !== 1'b0) begin nerr++; $display("FAIL full_ready r%0d: got %b want 0", r, cready); end
      regwrite = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        #1;
        nvec++; if (we !== 1'b1 || waddr !== 5'(j) || wdata !== 32'(r * 16 + j)) begin
          nerr++; $display("FAIL wrap_drain r%0d j%0d: got we=%b a=%0d d=%h want 1 %0d %h", r, j, we, waddr, wdata, j, r * 16 + j); end
        if (j <= 2) begin
          nvec++; if (cready !== (j == 2)) begin
            nerr++; $display("FAIL wrap_ready r%0d j%0d: got %b want %b", r, j, cready, j == 2); end
        end
        cyc();
      end
      #1;
      nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL wrap_busy r%0d: got %b want 0", r, busy); end
    end
  endtask

  task automatic test_kill();
    cyc();
    cvalid = 1'b1; crd = 5'd3; cdata = 32'h11; regwrite = 1'b0; #1;
    nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL kill_push_we: got %b want 0", we); end
    cyc();
    crd = 5'd4; cdata = 32'h44;
    regwrite = 1'b1; rdaddr = 5'd3; memtoreg = 1'b0; alu = 32'h22; #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h22) begin
      nerr++; $display("FAIL kill_pipe: got we=%b a=%0d d=%h want 1 3 22", we, waddr, wdata); end
    cyc();
    cvalid = 1'b0; regwrite = 1'b0; #1;
    nvec++; if (we !== 1'b0 || busy !== 1'b1) begin
      nerr++; $display("FAIL kill_silent_pop: got we=%b busy=%b want 0 1", we, busy); end
    cyc(); #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd4 || wdata !== 32'h44) begin
      nerr++; $display("FAIL kill_next: got we=%b a=%0d d=%h want 1 4 44", we, waddr, wdata); end
    nvec++; if (rf[3] !== 32'h22) begin nerr++; $display("FAIL kill_rf3: got %h want 22", rf[3]); end
    cyc();
    // same-cycle push is newer than the pipeline write and survives
    cvalid = 1'b1; crd = 5'd3; cdata = 32'h33; regwrite = 1'b1; rdaddr = 5'd3; alu = 32'h55; #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h55) begin
      nerr++; $display("FAIL kill_same_pipe: got we=%b a=%0d d=%h want 1 3 55", we, waddr, wdata); end
    cyc();
    cvalid = 1'b0; regwrite = 1'b0; #1;
    nvec++; if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h33) begin
      nerr++; $display("FAIL kill_same_keep: got we=%b a=%0d d=%h want 1 3 33", we, waddr, wdata); end
    cyc();
    cvalid = 1'b1; crd = 5'd0; cdata = 32'h77; #1;
    nvec++; if (cready !== 1'b1) begin nerr++; $display("FAIL rd0_ready: got %b want 1", cready); end
    cyc();
    cvalid = 1'b0; #1;
    nvec++; if (busy !== 1'b0 || we !== 1'b0) begin
      nerr++; $display("FAIL rd0_discard: got busy=%b we=%b want 0 0", busy, we); end
  endtask

  task automatic test_starvation();
    cyc();
    cvalid = 1'b1; crd = 5'd6; cdata = 32'h66;
    regwrite = 1'b1; rdaddr = 5'd9; memtoreg = 1'b0; alu = 32'h99;
    cyc();
    cvalid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      #1;
      nvec++; if (stall !== 1'b0 || we !== 1'b1 || waddr !== 5'd9) begin
        nerr++; $display("FAIL starve_wait n%0d: got stall=%b we=%b a=%0d want 0 1 9", n, stall, we, waddr); end
      cyc();
    end
    #1;
    nvec++; if (stall !== 1'b1 || we !== 1'b1 || waddr !== 5'd6 || wdata !== 32'h66) begin
      nerr++; $display("FAIL starve_fire: got stall=%b we=%b a=%0d d=%h want 1 1 6 66", stall, we, waddr, wdata); end
    cyc(); #1;
    nvec++; if (stall !== 1'b0 || we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h99 || busy !== 1'b0) begin
      nerr++; $display("FAIL starve_after: got stall=%b we=%b a=%0d d=%h busy=%b want 0 1 9 99 0", stall, we, waddr, wdata, busy); end
    regwrite = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    cyc();
    cvalid = 1'b1; crd = 5'd8; cdata = 32'h88;
    cyc();
    cvalid = 1'b0; rst = 1'b1; #1;
    nvec++; if (we !== 1'b0) begin nerr++; $display("FAIL rstmid_we: got %b want 0", we); end
    cyc();
    rst = 1'b0; #1;
    nvec++; if (busy !== 1'b0 || we !== 1'b0 || cready !== 1'b1) begin
      nerr++; $display("FAIL rstmid_after: got busy=%b we=%b ready=%b want 0 0 1", busy, we, cready); end
  endtask

  initial begin
    rst = 1'b1; alu = '0; dmem = '0; cdata = '0; rdaddr = '0; crd = '0;
    regwrite = 1'b0; memtoreg = 1'b0; cvalid = 1'b0;
    test_reset();
    test_pipe_select();
    test_drain();
    test_full_wrap();
    test_kill();
    test_starvation();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
